// File: rtl/peripheral_noc_vchannel_mux.sv
// Link-side virtual-channel multiplexer: one FIFO per VC, flit-level round-robin
// onto a shared flit bus with one-hot per-VC valid toward a router input port.
module peripheral_noc_vchannel_mux #(
  parameter int FLIT_WIDTH   = 32,
  parameter int VCHANNELS    = 2,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VCHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]            in_last,
  input  logic [VCHANNELS-1:0]            in_valid,
  output logic [VCHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic                            out_last,
  output logic [VCHANNELS-1:0]            out_valid,
  input  logic [VCHANNELS-1:0]            out_ready
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int VC_W  = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  typedef struct packed {
    logic                  last;
    logic [FLIT_WIDTH-1:0] flit;
  } entry_t;

  entry_t           mem_q    [VCHANNELS][BUFFER_DEPTH];
  entry_t           mem_d    [VCHANNELS][BUFFER_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [VCHANNELS];
  logic [PTR_W-1:0] wr_ptr_d [VCHANNELS];
  logic [PTR_W-1:0] rd_ptr_q [VCHANNELS];
  logic [PTR_W-1:0] rd_ptr_d [VCHANNELS];
  logic [CNT_W-1:0] count_q  [VCHANNELS];
  logic [CNT_W-1:0] count_d  [VCHANNELS];
  logic [VC_W-1:0]  rr_q;
  logic [VC_W-1:0]  rr_d;

  logic [VCHANNELS-1:0] empty;
  logic [VCHANNELS-1:0] full;
  logic [VCHANNELS-1:0] eligible;
  logic [VCHANNELS-1:0] push;
  logic [VCHANNELS-1:0] pop;
  logic [VC_W-1:0]      sel;
  logic                 sel_vld;
  entry_t               head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFFER_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Ready comes from the registered count only, so a full FIFO refuses a flit
  // even in a cycle where it is also popped.
  always_comb begin
    for (int v = 0; v < VCHANNELS; v++) begin
      empty[v]    = (count_q[v] == '0);
      full[v]     = (count_q[v] == CNT_W'(BUFFER_DEPTH));
      in_ready[v] = rst & ~full[v];
      eligible[v] = rst & ~empty[v] & out_ready[v];
      push[v]     = in_valid[v] & in_ready[v];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [VC_W-1:0] idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < VCHANNELS; i++) begin
      idx = VC_W'((int'(rr_q) + i) % VCHANNELS);
      if (!sel_vld && eligible[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_flit  = '0;
    out_last  = 1'b0;
    head      = '0;
    if (sel_vld) begin
      head           = mem_q[sel][rd_ptr_q[sel]];
      out_valid[sel] = 1'b1;
      out_flit       = head.flit;
      out_last       = head.last;
    end
    pop = out_valid;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (push[v]) begin
        mem_d[v][wr_ptr_q[v]] = '{last: in_last[v],
                                  flit: in_flit[v*FLIT_WIDTH +: FLIT_WIDTH]};
        wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
      end
      if (pop[v]) rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
      case ({push[v], pop[v]})
        2'b10:   count_d[v] = count_q[v] + CNT_W'(1);
        2'b01:   count_d[v] = count_q[v] - CNT_W'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  // Pointer advances past the VC that actually transferred; otherwise holds.
  always_comb begin
    rr_d = rr_q;
    if (sel_vld) rr_d = (sel == VC_W'(VCHANNELS - 1)) ? '0 : sel + VC_W'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      count_q  <= '{default: '0};
      rr_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // NOTE: storage is not reset; occupancy lives in count_q, which is.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_peripheral_noc_vchannel_mux.sv
// Bench for peripheral_noc_vchannel_mux: directed scenarios then random traffic,
// with expectations from per-VC queues and a round-robin rule kept in the bench.
module tb_peripheral_noc_vchannel_mux;

  localparam int FW    = 32;
  localparam int VC    = 2;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [VC*FW-1:0]  in_flit;
  logic [VC-1:0]     in_last;
  logic [VC-1:0]     in_valid;
  logic [VC-1:0]     in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_last;
  logic [VC-1:0]     out_valid;
  logic [VC-1:0]     out_ready;

  always #5 clk = ~clk;

  peripheral_noc_vchannel_mux #(
    .FLIT_WIDTH  (FW),
    .VCHANNELS   (VC),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (in_flit),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic          last;
    logic [FW-1:0] flit;
  } ent_t;

  typedef struct {
    logic [VC-1:0] in_ready;
    logic [VC-1:0] out_valid;
    logic [FW-1:0] flit;
    logic          last;
  } exp_t;

  ent_t mq [VC][$];
  exp_t exp_q [$];
  exp_t mon_e;
  int   rr_m;
  int   vectors;
  int   miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("in_ready",  64'(in_ready),  64'(mon_e.in_ready));
      check("out_valid", 64'(out_valid), 64'(mon_e.out_valid));
      check("out_flit",  64'(out_flit),  64'(mon_e.flit));
      check("out_last",  64'(out_last),  64'(mon_e.last));
    end
  end

  // Drive one cycle of stimulus, predict the response, then advance the model.
  task automatic step(input logic r, input logic [VC-1:0] iv, input logic [FW-1:0] f0,
                      input logic [FW-1:0] f1, input logic [VC-1:0] ls,
                      input logic [VC-1:0] ordy);
    exp_t e;
    ent_t n;
    int   sel;
    int   v;
    rst       = r;
    in_valid  = iv;
    in_flit   = {f1, f0};
    in_last   = ls;
    out_ready = ordy;
    e.in_ready  = '0;
    e.out_valid = '0;
    e.flit      = '0;
    e.last      = 1'b0;
    sel = -1;
    if (r) begin
      for (int k = 0; k < VC; k++) e.in_ready[k] = (mq[k].size() < DEPTH);
      for (int i = 0; i < VC; i++) begin
        v = (rr_m + i) % VC;
        if (sel < 0 && mq[v].size() > 0 && ordy[v]) sel = v;
      end
      if (sel >= 0) begin
        e.out_valid[sel] = 1'b1;
        e.flit           = mq[sel][0].flit;
        e.last           = mq[sel][0].last;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!r) begin
      for (int k = 0; k < VC; k++) mq[k].delete();
      rr_m = 0;
    end else begin
      if (sel >= 0) begin
        void'(mq[sel].pop_front());
        rr_m = (sel + 1) % VC;
      end
      for (int k = 0; k < VC; k++) begin
        if (iv[k] && e.in_ready[k]) begin
          n.last = ls[k];
          n.flit = (k == 0) ? f0 : f1;
          mq[k].push_back(n);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [VC-1:0] ordy);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0, ordy);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rr_m        = 0;
    rst         = 1'b0;
    in_valid    = '0;
    in_flit     = '0;
    in_last     = '0;
    out_ready   = '0;
    @(posedge clk);
    #1;

    // Reset held with all inputs valid, then released.
    step(1'b0, 2'b11, 32'h1, 32'h2, 2'b11, 2'b11);
    step(1'b0, 2'b11, 32'h1, 32'h2, 2'b11, 2'b11);
    idle(1, 2'b11);

    // Single 3-flit packet on VC0.
    step(1'b1, 2'b01, 32'hA0, '0, 2'b00, 2'b11);
    step(1'b1, 2'b01, 32'hA1, '0, 2'b00, 2'b11);
    step(1'b1, 2'b01, 32'hA2, '0, 2'b01, 2'b11);
    idle(3, 2'b11);

    // Interleave: both VCs pre-loaded, RR restarted at VC0.
    step(1'b0, '0, '0, '0, '0, 2'b00);
    step(1'b1, 2'b11, 32'hB0, 32'hC0, 2'b00, 2'b00);
    step(1'b1, 2'b11, 32'hB1, 32'hC1, 2'b11, 2'b00);
    idle(5, 2'b11);

    // Backpressure on VC0 only, then release.
    for (int k = 0; k < 4; k++)
      step(1'b1, 2'b11, 32'hD0 + FW'(k), 32'hE0 + FW'(k), 2'b00, 2'b10);
    idle(6, 2'b11);

    // Full FIFO offered a flit in the same cycle it is popped.
    step(1'b1, 2'b01, 32'hF0, '0, 2'b00, 2'b00);
    step(1'b1, 2'b01, 32'hF1, '0, 2'b00, 2'b00);
    step(1'b1, 2'b01, 32'hF2, '0, 2'b00, 2'b01);
    idle(1, 2'b00);
    idle(3, 2'b11);

    // Reset in the middle of a packet.
    step(1'b1, 2'b01, 32'h10, '0, 2'b00, 2'b00);
    step(1'b0, '0, '0, '0, '0, 2'b00);
    step(1'b1, 2'b11, 32'h20, 32'h30, 2'b00, 2'b00);
    idle(3, 2'b11);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 199) != 0), VC'($urandom), $urandom, $urandom,
           VC'($urandom), VC'($urandom));
    end
    idle(8, 2'b11);

    // Monitor should have consumed every expectation; bounded wait just in case.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
